fp_multiplier_pipelined: RTL and testbench
==========================================

Name: fp_multiplier_pipelined

Overview:
- Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier with valid/ready handshakes on input and output.
- Generalises the combinational single-precision multiplier to arbitrary exponent and mantissa widths.
- Adds round-to-nearest-even, NaN/Inf handling and sticky-free per-result exception flags.
- Sits in the float_arithmetic component library as the datapath multiplier for mixed-precision float layers.

Parameters:
- EXP_WIDTH, 8, exponent field width (>=3).
- MAN_WIDTH, 23, stored mantissa width, hidden bit excluded (>=2).
- DATA_WIDTH, 1+EXP_WIDTH+MAN_WIDTH, derived, do not override.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- data_in_0  input  DATA_WIDTH  operand A, layout {sign, exp, man}.
- data_in_1  input  DATA_WIDTH  operand B, same layout.
- data_in_valid  input  1  operands valid.
- data_in_ready  output  1  block accepts operands.
- data_out_0  output  DATA_WIDTH  product.
- data_out_flags  output  4  {invalid, overflow, underflow, inexact}, aligned with data_out_0.
- data_out_valid  output  1  product valid.
- data_out_ready  input  1  downstream accepts product.

Behaviour:
- Constants: BIAS = 2^(EXP_WIDTH-1)-1; EMAX = all-ones exponent.
- Reset (asynchronous, rst=1): all stage valid bits = 0; data_out_valid = 0; data_out_0 = 0; data_out_flags = 0. Reset mid-operation discards in-flight results; none reappear after reset.
- Handshake:
  - Transfer occurs on valid & ready at a rising clk edge.
  - stall = data_out_valid & !data_out_ready.
  - data_in_ready = !stall, combinational, no dependence on data_in_valid.
  - While stall holds, all stages and data_out_* hold their values.
  - data_out_* stay stable while valid & !ready.
- Latency: exactly 3 cycles from accepted input to data_out_valid, no stall assumed. Throughput is 1 per cycle. Bubbles propagate as valid=0.
- S1, unpack and multiply:
  - sign = sA ^ sB.
  - Classify each operand:
    - zero: exp == 0. Subnormals are flushed to zero and raise no flag.
    - inf: exp == EMAX and man == 0.
    - nan: exp == EMAX and man != 0.
  - Register the (2*MAN_WIDTH+2)-bit product of {1,manA}*{1,manB}.
  - Register expA+expB as an (EXP_WIDTH+2)-bit value, with no signed overflow possible.
- S2, normalise:
  - If product MSB = 1: take the MAN_WIDTH bits below the MSB, exponent += 1.
  - Else shift left by 1.
  - Unbiased result exponent e = expA+expB-BIAS+norm, held signed in EXP_WIDTH+2 bits.
  - Form guard = first dropped bit; sticky = OR of all remaining dropped bits.
- S3, round and pack:
  - RNE: round up iff guard & (sticky | lsb).
  - A mantissa carry-out sets mantissa = 0 and adds e += 1.
  - Priority, highest first:
    - Any NaN, or inf*zero: data_out_0 = {0, EMAX, 1 followed by zeros} (canonical qNaN); invalid = 1.
    - Any inf: {sign, EMAX, 0}; no flags.
    - Any zero: {sign, 0, 0}; no flags.
    - e >= EMAX: {sign, EMAX, 0}; overflow = 1, inexact = 1.
    - e <= 0: {sign, 0, 0}; underflow = 1, inexact = 1.
    - Otherwise: {sign, e[EXP_WIDTH-1:0], rounded mantissa}; inexact = guard | sticky.
  - Flags are per result, not accumulated.
- Simultaneous accept and output: when data_out_valid & data_out_ready and data_in_valid occur in the same cycle, both transfers occur and the pipeline advances.

Test Plan:
- Basic multiply, fp32 defaults: 0x3FC00000 * 0x40000000 -> data_out_0 = 0x40400000, flags = 0, valid exactly 3 cycles after accept.
- RNE tie to even: 0x3F800001 * 0x3FC00000 -> 0x3FC00002, inexact = 1. Below-half case: 0x3F800001 * 0x3F800001 -> 0x3F800002, inexact = 1.
- Specials:
  - 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid = 1.
  - 0xFF800000 * 0x40000000 -> 0xFF800000, flags = 0.
  - 0x7FC00001 * 0x3F800000 -> 0x7FC00000, invalid = 1.
- Overflow/underflow:
  - 0x7F000000 * 0x40000000 -> 0x7F800000, overflow = 1, inexact = 1.
  - 0x80800000 * 0x3F000000 -> 0x80000000, underflow = 1, inexact = 1.
  - 0x00000001 * 0x3F800000 -> 0x00000000, flags = 0.
- Backpressure: stream 8 back-to-back products with data_out_ready held low for cycles 4-7 -> data_in_ready low exactly while stalled, outputs held stable, all 8 results delivered in order, none dropped or duplicated.
- Reset mid-stream, plus fp16 instance (EXP_WIDTH=5, MAN_WIDTH=10):
  - Assert rst with 3 results in flight -> data_out_valid = 0 immediately, no stale outputs after release.
  - fp16: 0x3E00 * 0x4000 -> 0x4200.
  - fp16: 0x7BFF * 0x4000 -> 0x7C00, overflow = 1.

Source files
------------

// File: rtl/fp_multiplier_pipelined.sv
// Parametrised 3-stage pipelined IEEE-754-style multiplier: unpack/multiply, normalise, round/pack.
// Subnormals flush to zero; round-to-nearest-even; per-result {invalid, overflow, underflow, inexact}.
module fp_multiplier_pipelined #(
  parameter int EXP_WIDTH  = 8,
  parameter int MAN_WIDTH  = 23,
  parameter int DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic [3:0]            data_out_flags,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);
  localparam int PW = 2 * MAN_WIDTH + 2;
  localparam int EW = EXP_WIDTH + 2;
  localparam logic [EXP_WIDTH-1:0]  EMAX   = '1;
  localparam logic signed [EW-1:0]  EMAX_S = $signed({2'b00, EMAX});
  localparam logic signed [EW-1:0]  BIAS_S = EW'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0]  ONE_S  = EW'(1);
  localparam logic signed [EW-1:0]  ZERO_S = EW'(0);

  logic en_s;

  logic                 s1_v_q, s1_v_d, s1_sign_q, s1_sign_d;
  logic                 s1_nan_q, s1_nan_d, s1_inf_q, s1_inf_d, s1_zero_q, s1_zero_d;
  logic [PW-1:0]        s1_prod_q, s1_prod_d;
  logic [EW-1:0]        s1_esum_q, s1_esum_d;

  logic                 s2_v_q, s2_v_d, s2_sign_q, s2_sign_d;
  logic                 s2_nan_q, s2_nan_d, s2_inf_q, s2_inf_d, s2_zero_q, s2_zero_d;
  logic [MAN_WIDTH-1:0] s2_mant_q, s2_mant_d;
  logic                 s2_guard_q, s2_guard_d, s2_sticky_q, s2_sticky_d;
  logic signed [EW-1:0] s2_exp_q, s2_exp_d;

  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [3:0]            flags_q, flags_d;
  logic                  valid_q, valid_d;

  logic [EXP_WIDTH-1:0] exp_a_s, exp_b_s;
  logic [MAN_WIDTH-1:0] man_a_s, man_b_s;
  logic                 nan_a_s, nan_b_s, inf_a_s, inf_b_s, zero_a_s, zero_b_s;

  assign en_s          = ~(valid_q & ~data_out_ready);
  assign data_in_ready = en_s;
  assign data_out_0     = out_q;
  assign data_out_flags = flags_q;
  assign data_out_valid = valid_q;

  assign exp_a_s  = data_in_0[DATA_WIDTH-2 -: EXP_WIDTH];
  assign exp_b_s  = data_in_1[DATA_WIDTH-2 -: EXP_WIDTH];
  assign man_a_s  = data_in_0[MAN_WIDTH-1:0];
  assign man_b_s  = data_in_1[MAN_WIDTH-1:0];
  assign zero_a_s = (exp_a_s == '0);
  assign zero_b_s = (exp_b_s == '0);
  assign inf_a_s  = (exp_a_s == EMAX) && (man_a_s == '0);
  assign inf_b_s  = (exp_b_s == EMAX) && (man_b_s == '0);
  assign nan_a_s  = (exp_a_s == EMAX) && (man_a_s != '0);
  assign nan_b_s  = (exp_b_s == EMAX) && (man_b_s != '0);

  // S1: classify operands (inf*zero folded into nan) and form the raw significand product.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_sign_d = s1_sign_q;
    s1_nan_d  = s1_nan_q;
    s1_inf_d  = s1_inf_q;
    s1_zero_d = s1_zero_q;
    s1_prod_d = s1_prod_q;
    s1_esum_d = s1_esum_q;
    if (en_s) begin
      s1_v_d    = data_in_valid;
      s1_sign_d = data_in_0[DATA_WIDTH-1] ^ data_in_1[DATA_WIDTH-1];
      s1_nan_d  = nan_a_s | nan_b_s | (inf_a_s & zero_b_s) | (inf_b_s & zero_a_s);
      s1_inf_d  = inf_a_s | inf_b_s;
      s1_zero_d = zero_a_s | zero_b_s;
      s1_prod_d = PW'({1'b1, man_a_s}) * PW'({1'b1, man_b_s});
      s1_esum_d = EW'(exp_a_s) + EW'(exp_b_s);
    end else begin
      s1_v_d = s1_v_q;
    end
  end

  // S2: normalise the product and split off guard/sticky bits.
  always_comb begin
    s2_v_d      = s2_v_q;
    s2_sign_d   = s2_sign_q;
    s2_nan_d    = s2_nan_q;
    s2_inf_d    = s2_inf_q;
    s2_zero_d   = s2_zero_q;
    s2_mant_d   = s2_mant_q;
    s2_guard_d  = s2_guard_q;
    s2_sticky_d = s2_sticky_q;
    s2_exp_d    = s2_exp_q;
    if (en_s) begin
      s2_v_d    = s1_v_q;
      s2_sign_d = s1_sign_q;
      s2_nan_d  = s1_nan_q;
      s2_inf_d  = s1_inf_q;
      s2_zero_d = s1_zero_q;
      if (s1_prod_q[PW-1]) begin
        s2_mant_d   = s1_prod_q[PW-2 -: MAN_WIDTH];
        s2_guard_d  = s1_prod_q[MAN_WIDTH];
        s2_sticky_d = |s1_prod_q[MAN_WIDTH-1:0];
        s2_exp_d    = $signed(s1_esum_q) - BIAS_S + ONE_S;
      end else begin
        s2_mant_d   = s1_prod_q[PW-3 -: MAN_WIDTH];
        s2_guard_d  = s1_prod_q[MAN_WIDTH-1];
        s2_sticky_d = |s1_prod_q[MAN_WIDTH-2:0];
        s2_exp_d    = $signed(s1_esum_q) - BIAS_S;
      end
    end else begin
      s2_v_d = s2_v_q;
    end
  end

  logic                 rup_s;
  logic [MAN_WIDTH:0]   mant_r_s;
  logic [MAN_WIDTH-1:0] mant_f_s;
  logic signed [EW-1:0] exp_f_s;

  // S3: round to nearest even, then resolve specials and range in priority order.
  always_comb begin
    rup_s    = s2_guard_q & (s2_sticky_q | s2_mant_q[0]);
    mant_r_s = {1'b0, s2_mant_q} + {{MAN_WIDTH{1'b0}}, rup_s};
    if (mant_r_s[MAN_WIDTH]) begin
      mant_f_s = '0;
      exp_f_s  = s2_exp_q + ONE_S;
    end else begin
      mant_f_s = mant_r_s[MAN_WIDTH-1:0];
      exp_f_s  = s2_exp_q;
    end
    out_d   = out_q;
    flags_d = flags_q;
    valid_d = valid_q;
    if (en_s) begin
      valid_d = s2_v_q;
      if (s2_nan_q) begin
        out_d   = {1'b0, EMAX, 1'b1, {(MAN_WIDTH-1){1'b0}}};
        flags_d = 4'b1000;
      end else if (s2_inf_q) begin
        out_d   = {s2_sign_q, EMAX, {MAN_WIDTH{1'b0}}};
        flags_d = 4'b0000;
      end else if (s2_zero_q) begin
        out_d   = {s2_sign_q, {(EXP_WIDTH+MAN_WIDTH){1'b0}}};
        flags_d = 4'b0000;
      end else if (exp_f_s >= EMAX_S) begin
        out_d   = {s2_sign_q, EMAX, {MAN_WIDTH{1'b0}}};
        flags_d = 4'b0101;
      end else if (exp_f_s <= ZERO_S) begin
        out_d   = {s2_sign_q, {(EXP_WIDTH+MAN_WIDTH){1'b0}}};
        flags_d = 4'b0011;
      end else begin
        out_d   = {s2_sign_q, exp_f_s[EXP_WIDTH-1:0], mant_f_s};
        flags_d = {3'b000, s2_guard_q | s2_sticky_q};
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Pipeline registers; a stall is expressed through the _d holds above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0; s1_sign_q <= 1'b0; s1_nan_q <= 1'b0; s1_inf_q <= 1'b0; s1_zero_q <= 1'b0;
      s1_prod_q <= '0; s1_esum_q <= '0;
      s2_v_q <= 1'b0; s2_sign_q <= 1'b0; s2_nan_q <= 1'b0; s2_inf_q <= 1'b0; s2_zero_q <= 1'b0;
      s2_mant_q <= '0; s2_guard_q <= 1'b0; s2_sticky_q <= 1'b0; s2_exp_q <= '0;
      out_q <= '0; flags_q <= 4'b0000; valid_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d; s1_sign_q <= s1_sign_d; s1_nan_q <= s1_nan_d; s1_inf_q <= s1_inf_d;
      s1_zero_q <= s1_zero_d; s1_prod_q <= s1_prod_d; s1_esum_q <= s1_esum_d;
      s2_v_q <= s2_v_d; s2_sign_q <= s2_sign_d; s2_nan_q <= s2_nan_d; s2_inf_q <= s2_inf_d;
      s2_zero_q <= s2_zero_d; s2_mant_q <= s2_mant_d; s2_guard_q <= s2_guard_d;
      s2_sticky_q <= s2_sticky_d; s2_exp_q <= s2_exp_d;
      out_q <= out_d; flags_q <= flags_d; valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_fp_multiplier_pipelined.sv
// Scoreboard bench for fp_multiplier_pipelined: fp32 and fp16 instances, directed vectors.
module tb_fp_multiplier_pipelined;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in0 = 32'h0, in1 = 32'h0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] out0;
  logic [3:0]  flags;
  logic [15:0] h_in0 = 16'h0, h_in1 = 16'h0, h_out;
  logic        h_valid = 1'b0, h_in_ready, h_out_valid, h_out_ready = 1'b1;
  logic [3:0]  h_flags;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct { logic [31:0] d; logic [3:0] f; int acc; bit lat; } exp_t;
  exp_t q[$];
  exp_t q16[$];

  bit          prev_stall = 1'b0;
  logic [31:0] prev_out;
  logic [3:0]  prev_flags;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_multiplier_pipelined dut (
    .clk(clk), .rst(rst), .data_in_0(in0), .data_in_1(in1), .data_in_valid(in_valid),
    .data_in_ready(in_ready), .data_out_0(out0), .data_out_flags(flags),
    .data_out_valid(out_valid), .data_out_ready(out_ready));

  fp_multiplier_pipelined #(.EXP_WIDTH(5), .MAN_WIDTH(10)) dut16 (
    .clk(clk), .rst(rst), .data_in_0(h_in0), .data_in_1(h_in1), .data_in_valid(h_valid),
    .data_in_ready(h_in_ready), .data_out_0(h_out), .data_out_flags(h_flags),
    .data_out_valid(h_out_valid), .data_out_ready(h_out_ready));

  // fp32 monitor: handshake relation, hold-while-stalled, in-order scoreboard and latency.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++;
        $display("FAIL in_ready got %b want %b", in_ready, !(out_valid && !out_ready));
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out0 !== prev_out || flags !== prev_flags) begin
          errors++;
          $display("FAIL stall_hold got v=%b %h/%h want v=1 %h/%h", out_valid, out0, flags, prev_out, prev_flags);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got %h want none", out0);
        end else begin
          e = q.pop_front();
          if (out0 !== e.d || flags !== e.f) begin
            errors++;
            $display("FAIL result got %h/%b want %h/%b", out0, flags, e.d, e.f);
          end
          if (e.lat) begin
            checks++;
            if (cyc != e.acc + 3) begin
              errors++;
              $display("FAIL latency got %0d want 3", cyc - e.acc);
            end
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out0;
      prev_flags = flags;
    end
  end

  // fp16 monitor.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && h_out_valid) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL fp16_unexpected got %h want none", h_out);
      end else begin
        e = q16.pop_front();
        if (h_out !== e.d[15:0] || h_flags !== e.f) begin
          errors++;
          $display("FAIL fp16_result got %h/%b want %h/%b", h_out, h_flags, e.d[15:0], e.f);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ed,
                      input logic [3:0] ef, input bit lat);
    exp_t e;
    int n = 0;
    @(negedge clk);
    in0 = a; in1 = b; in_valid = 1'b1;
    forever begin
      #1;
      if (in_ready) begin
        e.d = ed; e.f = ef; e.acc = cyc; e.lat = lat;
        q.push_back(e);
        @(posedge clk);
        break;
      end
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout got ready=0 want ready=1");
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ed,
                        input logic [3:0] ef);
    exp_t e;
    @(negedge clk);
    h_in0 = a; h_in1 = b; h_valid = 1'b1;
    e.d = {16'h0, ed}; e.f = ef; e.acc = cyc; e.lat = 1'b0;
    q16.push_back(e);
    @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q16.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0 || q16.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0", q.size(), q16.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    checks++;
    if (out_valid !== 1'b0 || out0 !== 32'h0 || flags !== 4'h0 || h_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b %h/%b want v=0 0/0", out_valid, out0, flags);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed fp32 vectors, each entry {a, b, expected, flags}.
    send(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1);
    send(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 1'b1);
    send(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 1'b1);
    send(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1'b1);
    send(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1'b1);
    send(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1'b1);
    send(32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 1'b1);
    send(32'h80800000, 32'h3F000000, 32'h80000000, 4'b0011, 1'b1);
    send(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1'b1);
    idle();
    drain();

    // Backpressure: 2^k * 2 = 2^(k+1), output ready dropped for 4 cycles mid-stream.
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(32'h3F800000 + (k << 23), 32'h40000000, 32'h40000000 + (k << 23), 4'b0000, 1'b0);
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (i > 0) @(negedge clk);
          #2;
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_low got %b want 0", in_ready);
          end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #2;
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_ready_high got %b want 1", in_ready);
        end
      end
    join
    drain();

    // Reset with three results held in flight.
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b0);
    send(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 1'b0);
    send(32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000, 1'b0);
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out0 !== 32'h0 || flags !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset got v=%b %h want v=0 0", out_valid, out0);
    end
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);

    // fp16 instance.
    send16(16'h3E00, 16'h4000, 16'h4200, 4'b0000);
    send16(16'h7BFF, 16'h4000, 16'h7C00, 4'b0101);
    @(negedge clk);
    h_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
